// File: rtl/reg_file_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_file_arb_pkg                                                           |
// | Shared types and constants for the two-client register-file arbiter.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package reg_file_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arb2                                                                    |
// | Two-way arbiter: round-robin by default, fixed R0 priority when            |
// | ARB_FIXED_PRIO_EN is defined.                                              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_arb2
  import reg_file_arb_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] winner_o
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = CLK ^ RST ^ update_i;
  assign winner_o  = req_i[0] ? 2'b01 : {req_i[1], 1'b0};
`else
  logic last_winner_q;
  logic last_winner_d;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    winner_o      = req_i;
    last_winner_d = last_winner_q;
    if (req_i == 2'b11) begin
      winner_o = (last_winner_q == REQ1) ? 2'b01 : 2'b10;
    end
    if (update_i && (winner_o != 2'b00)) begin
      last_winner_d = winner_o[1] ? REQ1 : REQ0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_winner_q <= REQ1;
    end else begin
      last_winner_q <= last_winner_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/reg_file_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | reg_file_arbiter                                                           |
// | Serialises two requesters onto one register file; fixed R0 priority        |
// | instead of round-robin when ARB_FIXED_PRIO_EN is defined.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module reg_file_arbiter
  import reg_file_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Req0,
  input  logic                  Wr0,
  input  logic [ADDR_WIDTH-1:0] Addr0,
  input  logic [DATA_WIDTH-1:0] WData0,
  output logic                  Gnt0,
  output logic                  RdValid0,
  input  logic                  Req1,
  input  logic                  Wr1,
  input  logic [ADDR_WIDTH-1:0] Addr1,
  input  logic [DATA_WIDTH-1:0] WData1,
  output logic                  Gnt1,
  output logic                  RdValid1,
  output logic [DATA_WIDTH-1:0] RdDataOut,
  output logic                  RfWrEn,
  output logic                  RfRdEn,
  output logic [ADDR_WIDTH-1:0] RfAddress,
  output logic [DATA_WIDTH-1:0] RfWrData,
  input  logic [DATA_WIDTH-1:0] RfRdData,
  output logic                  Busy
);

  state_t                state_q;
  logic                  op_q;
  logic                  owner_q;
  logic                  rf_wr_en_q;
  logic                  rf_rd_en_q;
  logic [ADDR_WIDTH-1:0] rf_addr_q;
  logic [DATA_WIDTH-1:0] rf_wr_data_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid0_q;
  logic                  rd_valid1_q;

  logic [1:0]            w_winner;
  logic                  w_grant_any;
  logic                  w_sel_wr;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;

  rr_arb2 u_arb (
    .CLK      (CLK),
    .RST      (RST),
    .req_i    ({Req1, Req0}),
    .update_i (w_grant_any),
    .winner_o (w_winner)
  );

  // Grant is combinational so the requester's fields are captured on the same edge.
  assign w_grant_any = (state_q == IDLE) && (w_winner != 2'b00) && !RST;
  assign w_sel_wr    = w_winner[1] ? Wr1    : Wr0;
  assign w_sel_addr  = w_winner[1] ? Addr1  : Addr0;
  assign w_sel_data  = w_winner[1] ? WData1 : WData0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      op_q         <= OP_RD;
      owner_q      <= REQ0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      rd_data_q    <= '0;
      rd_valid0_q  <= 1'b0;
      rd_valid1_q  <= 1'b0;
    end else begin
      rf_wr_en_q  <= 1'b0;
      rf_rd_en_q  <= 1'b0;
      rd_valid0_q <= 1'b0;
      rd_valid1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_grant_any) begin
            op_q         <= w_sel_wr;
            owner_q      <= w_winner[1] ? REQ1 : REQ0;
            rf_addr_q    <= w_sel_addr;
            rf_wr_data_q <= w_sel_data;
            rf_wr_en_q   <= (w_sel_wr == OP_WR);
            rf_rd_en_q   <= (w_sel_wr == OP_RD);
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          state_q <= (op_q == OP_WR) ? IDLE : CAPTURE;
        end
        CAPTURE: begin
          rd_data_q   <= RfRdData;
          rd_valid0_q <= (owner_q == REQ0);
          rd_valid1_q <= (owner_q == REQ1);
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Gnt0      = w_grant_any && w_winner[0];
  assign Gnt1      = w_grant_any && w_winner[1];
  assign RdValid0  = rd_valid0_q;
  assign RdValid1  = rd_valid1_q;
  assign RdDataOut = rd_data_q;
  assign RfWrEn    = rf_wr_en_q;
  assign RfRdEn    = rf_rd_en_q;
  assign RfAddress = rf_addr_q;
  assign RfWrData  = rf_wr_data_q;
  assign Busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_reg_file_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_reg_file_arbiter                                                        |
// | Self-checking bench: scenario table, per-cycle reference model, read       |
// | scoreboard. Expectations adapt to ARB_FIXED_PRIO_EN.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_reg_file_arbiter;
  import reg_file_arb_pkg::*;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct packed {
    logic        en;
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
  } op_t;

  typedef struct packed {
    logic        owner;
    logic [15:0] data;
    int          cyc;
  } sb_t;

  typedef struct {
    logic       rst;
    op_t        r0a, r0b, r1a, r1b;
    int         n;
    logic [3:0] ord;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Req0, Wr0, Gnt0, RdValid0;
  logic        Req1, Wr1, Gnt1, RdValid1;
  logic [2:0]  Addr0, Addr1, RfAddress;
  logic [15:0] WData0, WData1, RdDataOut, RfWrData, RfRdData;
  logic        RfWrEn, RfRdEn, Busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rst_applied = 1'b0;
  logic started = 1'b0;

  op_t  q0[$], q1[$];
  sb_t  sb[$];
  logic glog[$];

  logic [15:0] ref_mem [8];
  logic [15:0] rf_mem [8];
  logic [15:0] rf_rd_q;
  logic        last_m = 1'b1;
  int          exp_free = 0;
  logic        exec_pend = 1'b0;
  op_t         e_exec;

  always #5 CLK = ~CLK;

  reg_file_arbiter #(.ADDR_WIDTH(3), .DATA_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST),
    .Req0(Req0), .Wr0(Wr0), .Addr0(Addr0), .WData0(WData0), .Gnt0(Gnt0), .RdValid0(RdValid0),
    .Req1(Req1), .Wr1(Wr1), .Addr1(Addr1), .WData1(WData1), .Gnt1(Gnt1), .RdValid1(RdValid1),
    .RdDataOut(RdDataOut), .RfWrEn(RfWrEn), .RfRdEn(RfRdEn), .RfAddress(RfAddress),
    .RfWrData(RfWrData), .RfRdData(RfRdData), .Busy(Busy)
  );

  // Register file: synchronous write, one-cycle registered read.
  always @(posedge CLK) begin
    if (RfWrEn) rf_mem[RfAddress] <= RfWrData;
    if (RfRdEn) rf_rd_q <= rf_mem[RfAddress];
  end
  assign RfRdData = rf_rd_q;

  initial begin : cycle_count
    forever begin
      @(posedge CLK);
      cyc = cyc + 1;
      rst_applied = RST;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic op_t mk_wr(input logic [2:0] a, input logic [15:0] d);
    return '{en: 1'b1, wr: OP_WR, addr: a, data: d};
  endfunction

  function automatic op_t mk_rd(input logic [2:0] a);
    return '{en: 1'b1, wr: OP_RD, addr: a, data: 16'h0000};
  endfunction

  // Requesters: hold the head op until granted, then present the next or drop Req.
  initial begin : drv0
    logic g;
    Req0 = 1'b0; Wr0 = 1'b0; Addr0 = '0; WData0 = '0;
    forever begin
      @(negedge CLK); g = Gnt0;
      @(posedge CLK); #1;
      if (g && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0) begin
        Req0 = 1'b1; Wr0 = q0[0].wr; Addr0 = q0[0].addr; WData0 = q0[0].data;
      end else Req0 = 1'b0;
    end
  end

  initial begin : drv1
    logic g;
    Req1 = 1'b0; Wr1 = 1'b0; Addr1 = '0; WData1 = '0;
    forever begin
      @(negedge CLK); g = Gnt1;
      @(posedge CLK); #1;
      if (g && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) begin
        Req1 = 1'b1; Wr1 = q1[0].wr; Addr1 = q1[0].addr; WData1 = q1[0].data;
      end else Req1 = 1'b0;
    end
  end

  // Cycle-level reference: arbitration, occupancy, RF strobes, read returns.
  initial begin : monitor
    sb_t         e;
    logic        w, fw;
    logic [2:0]  fa;
    logic [15:0] fd;
    forever begin
      @(negedge CLK);
      if (rst_applied) begin
        started = 1'b1;
        chk("rst_rf_en", {RfWrEn, RfRdEn}, 0);
        chk("rst_rdvalid", {RdValid1, RdValid0}, 0);
        chk("rst_rddata", RdDataOut, 0);
        chk("rst_busy", Busy, 0);
      end
      if (RST) begin
        chk("rst_gnt", {Gnt1, Gnt0}, 0);
        sb.delete();
        exec_pend = 1'b0;
        last_m    = REQ1;
        exp_free  = cyc + 1;
      end else if (started) begin
        chk("rf_en_excl", RfWrEn & RfRdEn, 0);
        if (exec_pend) begin
          chk("exec_wr_en", RfWrEn, e_exec.wr);
          chk("exec_rd_en", RfRdEn, !e_exec.wr);
          chk("exec_addr", RfAddress, e_exec.addr);
          chk("exec_wdata", RfWrData, e_exec.data);
          exec_pend = 1'b0;
        end else chk("rf_en_off", {RfWrEn, RfRdEn}, 0);
        if (RdValid0 || RdValid1) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL rdvalid_unexpected: got RdValid0=%0b RdValid1=%0b, want no pulse (cycle %0d)",
                     RdValid0, RdValid1, cyc);
          end else begin
            e = sb.pop_front();
            chk("rdvalid_owner", {RdValid1, RdValid0}, e.owner ? 2'b10 : 2'b01);
            chk("rd_data", RdDataOut, e.data);
            chk("rd_latency", cyc, e.cyc);
          end
        end
        if (cyc < exp_free) begin
          chk("busy_hi", Busy, 1);
          chk("gnt_while_busy", {Gnt1, Gnt0}, 0);
        end else begin
          chk("busy_lo", Busy, 0);
          if (Req0 || Req1) begin
            w = (Req0 && Req1) ? (FIXED ? REQ0 : ~last_m) : Req1;
            chk("gnt_winner", {Gnt1, Gnt0}, w ? 2'b10 : 2'b01);
            glog.push_back(Gnt1);
            last_m = w;
            fw = w ? Wr1 : Wr0;
            fa = w ? Addr1 : Addr0;
            fd = w ? WData1 : WData0;
            e_exec    = '{en: 1'b1, wr: fw, addr: fa, data: fd};
            exec_pend = 1'b1;
            if (fw) begin
              ref_mem[fa] = fd;
              exp_free = cyc + 2;
            end else begin
              sb.push_back('{owner: w, data: ref_mem[fa], cyc: cyc + 3});
              exp_free = cyc + 3;
            end
          end else chk("gnt_idle", {Gnt1, Gnt0}, 0);
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0 || Busy !== 1'b0) && n < 300) begin
      @(posedge CLK); #2;
      n++;
    end
    chk(name, (n >= 300) ? 1 : 0, 0);
  endtask

  task automatic check_log(input string name, input int n, input logic [3:0] ord);
    chk({name, "_ngrants"}, glog.size(), n);
    for (int k = 0; k < n && k < glog.size(); k++)
      chk($sformatf("%s_grant%0d", name, k), glog[k], ord[k]);
  endtask

  vec_t vecs[7];
  op_t  c_nop;

  initial begin : main
    int n;
    c_nop = '0;
    // ord bit k = owner of the k-th grant in the scenario.
    vecs[0] = '{1'b1, mk_wr(3, 16'h000E), c_nop, mk_rd(3), c_nop, 2, 4'b0010};
    vecs[1] = '{1'b1, mk_wr(5, 16'h000A), mk_rd(5), mk_wr(7, 16'h0077), c_nop, 3,
                FIXED ? 4'b0100 : 4'b0010};
    vecs[2] = '{1'b0, c_nop, c_nop, mk_rd(7), c_nop, 1, 4'b0001};
    vecs[3] = '{1'b0, mk_rd(3), c_nop, mk_wr(3, 16'hBEEF), c_nop, 2, 4'b0010};
    vecs[4] = '{1'b0, mk_wr(1, 16'h1111), mk_rd(1), mk_wr(2, 16'h2222), mk_rd(3), 4,
                FIXED ? 4'b1100 : 4'b1010};
    vecs[5] = '{1'b0, mk_wr(6, 16'h6666), c_nop, c_nop, c_nop, 1, 4'b0000};
    vecs[6] = '{1'b0, mk_rd(6), c_nop, mk_rd(2), c_nop, 2, FIXED ? 4'b0010 : 4'b0001};

    for (int i = 0; i < 7; i++) begin
      @(posedge CLK); #2;
      glog.delete();
      if (vecs[i].rst) RST = 1'b1;
      if (vecs[i].r0a.en) q0.push_back(vecs[i].r0a);
      if (vecs[i].r0b.en) q0.push_back(vecs[i].r0b);
      if (vecs[i].r1a.en) q1.push_back(vecs[i].r1a);
      if (vecs[i].r1b.en) q1.push_back(vecs[i].r1b);
      if (vecs[i].rst) begin
        repeat (3) @(posedge CLK);
        #2 RST = 1'b0;
      end
      wait_idle($sformatf("row%0d_idle", i));
      check_log($sformatf("row%0d", i), vecs[i].n, vecs[i].ord);
    end

    // Saturation: both requesters always pending for 16 grants.
    @(posedge CLK); #2;
    glog.delete();
    RST = 1'b1;
    for (int k = 0; k < 8; k++) begin
      q0.push_back(mk_wr(3'(k), 16'h0100 + 16'(k)));
      q1.push_back(mk_wr(3'(k), 16'h0200 + 16'(k)));
    end
    repeat (3) @(posedge CLK);
    #2 RST = 1'b0;
    wait_idle("sat_idle");
    chk("sat_ngrants", glog.size(), 16);
    for (int k = 0; k < 16 && k < glog.size(); k++)
      chk($sformatf("sat_grant%0d", k), glog[k], FIXED ? ((k >= 8) ? 1 : 0) : (k % 2));

    // Reset while an R1 read sits in CAPTURE: the read is dropped.
    @(posedge CLK); #2;
    q1.push_back(mk_rd(5));
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (Gnt1 !== 1'b1 && n < 20);
    chk("midrd_gnt1_seen", (n < 20) ? 1 : 0, 1);
    @(posedge CLK);
    @(posedge CLK); #2;
    RST = 1'b1;
    @(posedge CLK); #2;
    RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("midrd_no_rdvalid1", RdValid1, 0);
    end
    chk("midrd_busy", Busy, 0);

    // After that reset R0 has priority again.
    @(posedge CLK); #2;
    glog.delete();
    q0.push_back(mk_wr(0, 16'h00AA));
    q1.push_back(mk_rd(0));
    wait_idle("post_rst_idle");
    check_log("post_rst", 2, 4'b0010);

    repeat (2) @(posedge CLK);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, want completion", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/reg_file_arbiter.md
Name: reg_file_arbiter

Overview:
- Shares one 8x16 register file (synchronous write, 1-cycle registered read) between two requesters, R0 and R1.
- Round-robin arbitration with a req/gnt handshake per requester.
- Serialises accesses into RF-side WrEn/RdEn/Address/WrData strobes and returns read data to the requester that owns the access.
- Sits between two client blocks and the register file instance.

Parameters:
- ADDR_WIDTH, 3, register file address width (8 entries).
- DATA_WIDTH, 16, register file data width.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  reset; synchronous, active-high
- Req0  in  1  R0 access request; held until Gnt0
- Wr0  in  1  R0 op: 1 = write, 0 = read
- Addr0  in  ADDR_WIDTH  R0 address
- WData0  in  DATA_WIDTH  R0 write data
- Gnt0  out  1  one-cycle grant pulse; R0 fields sampled on this edge
- RdValid0  out  1  one-cycle pulse; RdDataOut valid for R0
- Req1/Wr1/Addr1/WData1/Gnt1/RdValid1  same as R0, for R1
- RdDataOut  out  DATA_WIDTH  read data returned to owner, held until next read completes
- RfWrEn  out  1  to RF WrEn
- RfRdEn  out  1  to RF RdEn
- RfAddress  out  ADDR_WIDTH  to RF Address
- RfWrData  out  DATA_WIDTH  to RF WrData
- RfRdData  in  DATA_WIDTH  from RF RdData
- Busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (RST=1 at a rising edge):
  - All outputs go to 0, state goes to IDLE, last_winner=1 (so R0 has first priority).
  - Overrides any in-flight op. A pending read is dropped and no RdValid is issued.
- FSM states: IDLE, EXEC, CAPTURE.
- IDLE:
  - If any Req is high, pick a winner.
  - When both are high, the winner is the requester that is NOT last_winner.
  - Pulse Gnt of the winner, latch Wr/Addr/WData and the owner id, update last_winner, go to EXEC.
  - If no Req is high, stay in IDLE.
- EXEC (exactly one cycle):
  - RfAddress and RfWrData are driven from the latched values.
  - Write: RfWrEn=1, RfRdEn=0, then go to IDLE.
  - Read: RfRdEn=1, RfWrEn=0, then go to CAPTURE.
  - RfWrEn and RfRdEn are never both high.
  - Outside EXEC both enables are 0. RfAddress and RfWrData hold their last values.
- CAPTURE (one cycle):
  - RfRdData is valid. Register it into RdDataOut and pulse RdValid of the owner on the next edge.
  - Go to IDLE.
- Timing:
  - Write occupancy: 2 cycles. Read occupancy: 3 cycles. The RdValid pulse coincides with the first IDLE cycle after CAPTURE.
  - Back-to-back throughput is 1 write per 2 cycles, 1 read per 3 cycles.
  - Gnt is never asserted outside IDLE. Req during EXEC/CAPTURE waits and is not lost.
- Handshake:
  - A requester keeps Req and its fields stable until it sees Gnt.
  - It deasserts Req in the cycle after Gnt, unless it is issuing a new op.
  - Req still high the cycle after Gnt counts as a new request.
- Ordering and hazards:
  - A write followed by a read of the same address from the other requester returns the new data, because ops are serialised.
  - There is no starvation: with both requesters saturated, grants alternate strictly.
- The RdDataOut value is unchanged by writes.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: R0 always wins a simultaneous request; last_winner is not used and may be removed by synthesis. R1 is served only when Req0=0 in IDLE.
- Undefined: round-robin as above.

Decomposition:
- Package reg_file_arb_pkg holds:
  - the state enum (IDLE, EXEC, CAPTURE);
  - localparams OP_RD=0 and OP_WR=1;
  - owner id constants REQ0=0 and REQ1=1.
- One sub-module, rr_arb2:
  - Inputs: req[1:0], the update strobe, CLK, RST.
  - Output: the one-hot winner.
  - Holds last_winner internally.
  - Contains the ARB_FIXED_PRIO_EN variant.
- The FSM and datapath latches live in the top module.

Test Plan:
- Reset: hold RST=1 for 2 cycles with Req0=Req1=1 -> no Gnt, RfWrEn=RfRdEn=0, RdDataOut=0, Busy=0.
- R0 write addr 5 data 10, then R0 read addr 5 -> Gnt0, RfWrEn=1 with RfAddress=5 and RfWrData=10 the next cycle, then RdValid0=1 with RdDataOut=10 three cycles after the read Gnt0.
- Simultaneous requests: R0 writes addr 3 data 14 while R1 reads addr 3, both asserted in the same cycle after reset -> R0 granted first, R1 gets RdDataOut=14 with RdValid1 (RdValid0 stays 0).
- Both requests held saturated for 8 grants -> Gnt alternates R0, R1, R0, ... and 4 grants each (round-robin build); all 8 go to R0 when ARB_FIXED_PRIO_EN is defined.
- Reset mid-read: assert RST during CAPTURE of an R1 read of addr 5 -> no RdValid1; after release, IDLE with R0 priority.
- R1 holds Req1 across the EXEC of an R0 op -> R1 is granted in the first IDLE cycle afterwards with its fields intact; RfWrEn and RfRdEn are never high together in any cycle.
